nr_div_feeder: RTL and testbench

//  Host-side driver for the non-restoring divider. Buffers a dividend (N bits) and a divisor (M bits)
//  as Block-bit words, then streams them on the divider's beat protocol (one-cycle valid, then Ncnt

---
 rtl/nr_div_feeder_pkg.sv | 20 ++
 rtl/nr_div_feeder_if.sv | 31 +++
 rtl/nr_div_word_buf.sv | 24 ++
 rtl/nr_div_feeder.sv | 172 +++++++++++++++++
 tb/tb_nr_div_feeder.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nr_div_feeder_pkg.sv
// Shared definitions for the divider feeder: state encoding, word-count helper and
// the beat-protocol timing that the divider and its bench also rely on.
package nr_div_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
    WAIT,
    DONE
  } feeder_state_e;

  // Cycles from the div_valid strobe to the first data beat; beats are LSW first.
  localparam int VALID_LEAD = 1;

  function automatic int word_cnt(input int bits, input int block);
    return bits / block;
  endfunction

endpackage

// File: rtl/nr_div_feeder_if.sv
// Beat-protocol bus between the feeder (master) and the non-restoring divider (slave).
interface nr_div_feeder_if #(
  parameter int Block = 128
);

  logic             div_valid;
  logic             div_data_vld;
  logic [Block-1:0] div_dividend;
  logic [Block-1:0] div_divisor;
  logic [Block-1:0] div_quotient;
  logic             div_quot_vld;

  modport master (
    output div_valid,
    output div_data_vld,
    output div_dividend,
    output div_divisor,
    input  div_quotient,
    input  div_quot_vld
  );

  modport slave (
    input  div_valid,
    input  div_data_vld,
    input  div_dividend,
    input  div_divisor,
    output div_quotient,
    output div_quot_vld
  );

endinterface

// File: rtl/nr_div_word_buf.sv
// Word-wide register file: one synchronous write port, one combinational read port.
// Contents are deliberately not reset.
module nr_div_word_buf #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/nr_div_feeder.sv
// Host-side driver for the non-restoring divider: buffers operands, streams them as
// beats, collects the quotient words and pulses done (optionally with timeout_err).
//
// state | meaning
// IDLE  | operands writable, waiting for start
// START | div_valid strobe to the divider
// SEND  | Ncnt consecutive data beats, LSW first
// WAIT  | collecting Mcnt quotient words, timeout running
// DONE  | one-cycle done (and timeout_err if abandoned)
module nr_div_feeder
  import nr_div_feeder_pkg::*;
#(
  parameter  int N       = 4096,
  parameter  int M       = 2048,
  parameter  int Block   = 128,
  parameter  int TIMEOUT = 2**20,
  localparam int Ncnt    = word_cnt(N, Block),
  localparam int Mcnt    = word_cnt(M, Block),
  localparam int NAW     = $clog2(Ncnt),
  localparam int MAW     = $clog2(Mcnt)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_wr_en,
  input  logic             op_wr_sel,
  input  logic [NAW-1:0]   op_wr_addr,
  input  logic [Block-1:0] op_wr_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             timeout_err,
  input  logic [MAW-1:0]   res_rd_addr,
  output logic [Block-1:0] res_rd_data,
  nr_div_feeder_if.master  div_bus
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [NAW-1:0] LAST_BEAT = NAW'(Ncnt - 1);
  localparam logic [MAW-1:0] LAST_WORD = MAW'(Mcnt - 1);
  localparam logic [TW-1:0]  TMR_LOAD  = TW'(TIMEOUT - 1);

  feeder_state_e state_q, state_d;
  logic [NAW-1:0] beats_left_q, beats_left_d;
  logic [MAW-1:0] q_cnt_q, q_cnt_d;
  logic [TW-1:0]  tmr_q, tmr_d;
  logic           timeout_hit;
  logic           q_wr;
  logic [NAW-1:0] nxt_beat;
  logic           nxt_has_divisor;
  logic [Block-1:0] a_word, b_word;
  logic           a_wr, b_wr;

  logic             busy_q, done_q, to_q, valid_q, dvld_q;
  logic [Block-1:0] dividend_q, divisor_q;

  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    q_cnt_d      = q_cnt_q;
    tmr_d        = tmr_q;
    timeout_hit  = 1'b0;
    q_wr         = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = START;
          q_cnt_d = '0;
        end
      end
      START: begin
        state_d      = SEND;
        beats_left_d = LAST_BEAT;
      end
      SEND: begin
        if (beats_left_q == '0) begin
          state_d = WAIT;
          tmr_d   = TMR_LOAD;
        end else begin
          beats_left_d = beats_left_q - 1'b1;
        end
      end
      WAIT: begin
        q_wr = div_bus.div_quot_vld;
        if (div_bus.div_quot_vld) q_cnt_d = q_cnt_q + 1'b1;
        // A final word arriving on the expiry cycle still counts as a clean finish.
        if (div_bus.div_quot_vld && (q_cnt_q == LAST_WORD)) begin
          state_d = DONE;
        end else if (tmr_q == '0) begin
          state_d     = DONE;
          timeout_hit = 1'b1;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Word index of the beat that will be on the bus next cycle.
  assign nxt_beat        = (state_q == START) ? '0 : (LAST_BEAT - beats_left_q + 1'b1);
  assign nxt_has_divisor = int'(nxt_beat) < Mcnt;

  assign a_wr = op_wr_en && (state_q == IDLE) && !op_wr_sel;
  assign b_wr = op_wr_en && (state_q == IDLE) && op_wr_sel && (int'(op_wr_addr) < Mcnt);

  nr_div_word_buf #(.DEPTH(Ncnt), .WIDTH(Block)) u_dividend_buf (
    .clk     (clk),
    .wr_en   (a_wr),
    .wr_addr (op_wr_addr),
    .wr_data (op_wr_data),
    .rd_addr (nxt_beat),
    .rd_data (a_word)
  );

  nr_div_word_buf #(.DEPTH(Mcnt), .WIDTH(Block)) u_divisor_buf (
    .clk     (clk),
    .wr_en   (b_wr),
    .wr_addr (op_wr_addr[MAW-1:0]),
    .wr_data (op_wr_data),
    .rd_addr (nxt_beat[MAW-1:0]),
    .rd_data (b_word)
  );

  nr_div_word_buf #(.DEPTH(Mcnt), .WIDTH(Block)) u_quotient_buf (
    .clk     (clk),
    .wr_en   (q_wr),
    .wr_addr (q_cnt_q),
    .wr_data (div_bus.div_quotient),
    .rd_addr (res_rd_addr),
    .rd_data (res_rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beats_left_q <= '0;
      q_cnt_q      <= '0;
      tmr_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      to_q         <= 1'b0;
      valid_q      <= 1'b0;
      dvld_q       <= 1'b0;
      dividend_q   <= '0;
      divisor_q    <= '0;
    end else begin
      state_q      <= state_d;
      beats_left_q <= beats_left_d;
      q_cnt_q      <= q_cnt_d;
      tmr_q        <= tmr_d;
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
      to_q         <= timeout_hit;
      valid_q      <= (state_d == START);
      dvld_q       <= (state_d == SEND);
      if (state_d == SEND) begin
        dividend_q <= a_word;
        divisor_q  <= nxt_has_divisor ? b_word : '0;
      end
    end
  end

  assign busy                 = busy_q;
  assign done                 = done_q;
  assign timeout_err          = to_q;
  assign div_bus.div_valid    = valid_q;
  assign div_bus.div_data_vld = dvld_q;
  assign div_bus.div_dividend = dividend_q;
  assign div_bus.div_divisor  = divisor_q;

endmodule

// File: tb/tb_nr_div_feeder.sv
// Bench for nr_div_feeder: behavioural divider on the slave side, a timeline model of
// the expected feeder outputs checked every cycle, and directed literal checks.
module tb_nr_div_feeder;
  import nr_div_feeder_pkg::*;

  localparam int N = 512, M = 256, BLK = 128, TMO = 64;
  localparam int NC = 4, MC = 2, LAT = 4;

  logic           clk = 1'b0, rst_n = 1'b0;
  logic           op_wr_en = 1'b0, op_wr_sel = 1'b0, start = 1'b0;
  logic [1:0]     op_wr_addr = '0;
  logic [BLK-1:0] op_wr_data = '0;
  logic           busy, done, timeout_err;
  logic [0:0]     res_rd_addr = '0;
  logic [BLK-1:0] res_rd_data;

  nr_div_feeder_if #(.Block(BLK)) bus ();

  nr_div_feeder #(.N(N), .M(M), .Block(BLK), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_wr_en    (op_wr_en),
    .op_wr_sel   (op_wr_sel),
    .op_wr_addr  (op_wr_addr),
    .op_wr_data  (op_wr_data),
    .start       (start),
    .busy        (busy),
    .done        (done),
    .timeout_err (timeout_err),
    .res_rd_addr (res_rd_addr),
    .res_rd_data (res_rd_data),
    .div_bus     (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, done_cnt = 0;
  int model_words = 2;
  logic [BLK-1:0] junk = {4{32'hA5A5_5A5A}};

  always @(posedge clk) cyc++;
  always @(negedge clk) if (rst_n && done) done_cnt++;

  task automatic chk(input string nm, input logic [BLK-1:0] act, input logic [BLK-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Timeline model: start accepted in IDLE at cycle s -> div_valid at s+1, beats
  // s+2..s+1+NC, WAIT from there; done one cycle after the MC-th quotient strobe
  // or TMO cycles after WAIT entry.
  bit             act = 1'b0, te = 1'b0;
  int             s_m = -1, done_at = -1, qseen = 0, c_m, k_m, wait_at;
  bit             e_v, e_dv, e_done, e_busy;
  logic [BLK-1:0] exp_a [NC];
  logic [BLK-1:0] exp_b [MC];
  logic [BLK-1:0] exp_q [MC];
  bit             q_known [MC] = '{default: 1'b0};

  always @(negedge clk) begin
    c_m = cyc;
    if (!rst_n) begin
      act = 1'b0;
      chk("rst_div_valid", bus.div_valid, 0);
      chk("rst_div_data_vld", bus.div_data_vld, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_timeout_err", timeout_err, 0);
    end else begin
      wait_at = s_m + 1 + VALID_LEAD + NC;
      e_v    = act && (c_m == s_m + 1);
      e_dv   = act && (c_m >= s_m + 1 + VALID_LEAD) && (c_m < wait_at);
      e_done = act && (c_m == done_at);
      e_busy = act && (c_m > s_m);
      chk("div_valid", bus.div_valid, e_v);
      chk("div_data_vld", bus.div_data_vld, e_dv);
      chk("done", done, e_done);
      chk("timeout_err", timeout_err, e_done && te);
      chk("busy", busy, e_busy);
      if (e_dv) begin
        k_m = c_m - (s_m + 1 + VALID_LEAD);
        chk("beat_dividend", bus.div_dividend, exp_a[k_m]);
        chk("beat_divisor", bus.div_divisor, (k_m < MC) ? exp_b[k_m] : '0);
      end
      if (q_known[res_rd_addr]) chk("res_rd_data", res_rd_data, exp_q[res_rd_addr]);
      if (act && done_at < 0 && c_m >= wait_at) begin
        if (bus.div_quot_vld) begin
          exp_q[qseen]   = bus.div_quotient;
          q_known[qseen] = 1'b1;
          qseen++;
        end
        if (qseen == MC) begin
          done_at = c_m + 1;
          te      = 1'b0;
        end else if (c_m + 1 == wait_at + TMO) begin
          done_at = c_m + 1;
          te      = 1'b1;
        end
      end
      if (op_wr_en && !act) begin
        if (!op_wr_sel) exp_a[op_wr_addr] = op_wr_data;
        else if (op_wr_addr < MC) exp_b[op_wr_addr] = op_wr_data;
      end
      if (start && !act) begin
        act     = 1'b1;
        s_m     = c_m;
        done_at = -1;
        qseen   = 0;
      end else if (act && c_m == done_at) begin
        act = 1'b0;
      end
    end
  end

  // Behavioural divider: captures the beats after div_valid, returns model_words words.
  initial begin : divider
    logic [N-1:0] ca, cb, q;
    int nb;
    bus.div_quot_vld = 1'b0;
    bus.div_quotient = '0;
    nb = 0; ca = '0; cb = '0; q = '0;
    forever begin
      @(negedge clk);
      if (!rst_n || bus.div_valid) begin
        nb = 0;
      end else if (bus.div_data_vld && nb < NC) begin
        ca[nb*BLK +: BLK] = bus.div_dividend;
        cb[nb*BLK +: BLK] = bus.div_divisor;
        nb++;
        if (nb == NC) begin
          nb = 0;
          q  = (cb == '0) ? '1 : ca / cb;
          repeat (LAT) @(posedge clk);
          for (int w = 0; w < model_words; w++) begin
            @(posedge clk); #1;
            bus.div_quot_vld = 1'b1;
            bus.div_quotient = (w < MC) ? q[w*BLK +: BLK] : junk;
          end
          @(posedge clk); #1;
          bus.div_quot_vld = 1'b0;
        end
      end
    end
  end

  task automatic wr(input bit sel, input int addr, input logic [BLK-1:0] d);
    @(posedge clk); #1;
    op_wr_en = 1'b1; op_wr_sel = sel; op_wr_addr = 2'(addr); op_wr_data = d;
    @(posedge clk); #1;
    op_wr_en = 1'b0;
  endtask

  task automatic load(input logic [N-1:0] a, input logic [M-1:0] b);
    for (int i = 0; i < NC; i++) wr(1'b0, i, a[i*BLK +: BLK]);
    for (int i = 0; i < MC; i++) wr(1'b1, i, b[i*BLK +: BLK]);
  endtask

  task automatic go(output int s);
    @(posedge clk); #1;
    start = 1'b1;
    s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int dcyc, output bit tflag);
    dcyc = -1;
    tflag = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      res_rd_addr = ~res_rd_addr;
      @(negedge clk);
      if (done) begin
        dcyc  = cyc;
        tflag = timeout_err;
        break;
      end
    end
    if (dcyc < 0) begin
      total++;
      bad++;
      $display("FAIL wait_done: no done within %0d cycles", budget);
    end
  endtask

  task automatic rd(input string nm, input int addr, input logic [BLK-1:0] exp);
    @(posedge clk); #1;
    res_rd_addr = 1'(addr);
    #1;
    chk(nm, res_rd_data, exp);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int s, dc, dn0;
    bit tf;
    logic [N-1:0] a;
    logic [M-1:0] b;

    repeat (3) @(posedge clk); #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_timeout_err", timeout_err, 0);
    chk("reset_div_valid", bus.div_valid, 0);
    chk("reset_div_data_vld", bus.div_data_vld, 0);
    chk("reset_div_dividend", bus.div_dividend, 0);
    chk("reset_div_divisor", bus.div_divisor, 0);
    rst_n = 1'b1;

    // (2**300+5)/3 = 0x555...557 (75 hex digits)
    a = (N'(1) << 300) + N'(5);
    b = M'(3);
    load(a, b);
    go(s);
    wait_done(100, dc, tf);
    chk("t1_done_cycle", dc, s + 1 + VALID_LEAD + NC + LAT + 2);
    chk("t1_timeout_err", tf, 0);
    rd("t1_q0", 0, 128'h5555_5555_5555_5555_5555_5555_5555_5557);
    rd("t1_q1", 1, 128'h5555_5555_5555_5555_5555_5555_5555_5555);

    load('0, M'(1));
    go(s);
    wait_done(100, dc, tf);
    chk("t2_timeout_err", tf, 0);
    rd("t2_q0", 0, 0);
    rd("t2_q1", 1, 0);

    // start re-pulsed in SEND and WAIT, operand write in WAIT: all ignored
    load(N'(1000), M'(7));
    dn0 = done_cnt;
    go(s);
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk); #1;
    start = 1'b1; op_wr_en = 1'b1; op_wr_sel = 1'b0; op_wr_addr = 2'd0; op_wr_data = junk;
    @(posedge clk); #1;
    start = 1'b0; op_wr_en = 1'b0;
    wait_done(100, dc, tf);
    repeat (20) @(posedge clk); #1;
    chk("t3_one_done", done_cnt - dn0, 1);
    rd("t3_q0", 0, 128'd142);
    go(s);
    wait_done(100, dc, tf);
    rd("t3_rerun_q0", 0, 128'd142);
    rd("t3_rerun_q1", 1, 0);

    // one quotient word only: timeout, word 1 keeps its old value
    model_words = 1;
    load((N'(1) << 300) + N'(5), M'(3));
    go(s);
    wait_done(200, dc, tf);
    chk("t4_done_cycle", dc, s + 1 + VALID_LEAD + NC + TMO);
    chk("t4_timeout_err", tf, 1);
    rd("t4_q0", 0, 128'h5555_5555_5555_5555_5555_5555_5555_5557);
    rd("t4_q1", 1, 0);

    // three words returned: third ignored; 2**200 / 2**72 = 2**128
    model_words = 3;
    load(N'(1) << 200, M'(1) << 72);
    dn0 = done_cnt;
    go(s);
    wait_done(100, dc, tf);
    chk("t5_done_cycle", dc, s + 1 + VALID_LEAD + NC + LAT + 2);
    repeat (5) @(posedge clk); #1;
    chk("t5_one_done", done_cnt - dn0, 1);
    rd("t5_q0", 0, 0);
    rd("t5_q1", 1, 1);

    // reset during beat 2, then restart with the retained operands
    model_words = 2;
    load(N'(1000), M'(7));
    go(s);
    repeat (3) @(posedge clk); #1;
    chk("t6_beat2_vld", bus.div_data_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_data_vld", bus.div_data_vld, 0);
    chk("t6_rst_busy", busy, 0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    go(s);
    wait_done(100, dc, tf);
    chk("t6_timeout_err", tf, 0);
    rd("t6_q0", 0, 128'd142);
    rd("t6_q1", 1, 0);

    repeat (3) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
